// File: rtl/writeback_stage.sv
// Writeback stage: merges single-cycle ALU results and memory load
// results onto one register-file write port, tracks pending loads in
// a per-register scoreboard and signals completion after halt.
//
// Ports (writeback_stage):
//   clk, reset          clock, synchronous active-high reset
//   alu_valid/dest/data ALU result, strict priority on the write port
//   ld_issue/_dest      load issued to memory, marks destination busy
//   ld_valid/dest/data  load result offered by memory
//   ld_ready            offered load is accepted this cycle
//   halt                program reached its halt instruction
//   write/_address/_data registered register-file write port
//   busy                per-register pending-load scoreboard
//   complete            all results retired, register file may dump
//
// Ports (writeback_fifo): 2-entry load buffer, head at slot 0.

module writeback_fifo (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic [2:0]  push_dest_i,
    input  logic [15:0] push_data_i,
    input  logic        pop_i,
    output logic [2:0]  head_dest_o,
    output logic [15:0] head_data_o,
    output logic [1:0]  count_o
);

    logic [2:0]  dest_q [2];
    logic [15:0] data_q [2];
    logic [2:0]  dest_d [2];
    logic [15:0] data_d [2];
    logic [1:0]  count_q;
    logic [1:0]  count_d;

    always_comb begin
        dest_d  = dest_q;
        data_d  = data_q;
        count_d = count_q;
        if (pop_i) begin
            dest_d[0] = dest_q[1];
            data_d[0] = data_q[1];
            count_d   = count_q - 2'd1;
        end
        // A push lands in the first free slot after any pop, so a
        // simultaneous push/pop keeps order and count.
        if (push_i) begin
            dest_d[count_d[0]] = push_dest_i;
            data_d[count_d[0]] = push_data_i;
            count_d            = count_d + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload needs no reset: it is only observed through count.
    always_ff @(posedge clk) begin
        dest_q <= dest_d;
        data_q <= data_d;
    end

    assign head_dest_o = dest_q[0];
    assign head_data_o = data_q[0];
    assign count_o     = count_q;

endmodule

module writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [2:0]  alu_dest,
    input  logic [15:0] alu_data,
    input  logic        ld_issue,
    input  logic [2:0]  ld_issue_dest,
    input  logic        ld_valid,
    input  logic [2:0]  ld_dest,
    input  logic [15:0] ld_data,
    output logic        ld_ready,
    input  logic        halt,
    output logic        write,
    output logic [2:0]  write_address,
    output logic [15:0] write_data,
    output logic [7:0]  busy,
    output logic        complete
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e      state_q;
    logic        complete_q;

    logic        write_q;
    logic [2:0]  write_address_q;
    logic [15:0] write_data_q;
    logic        write_d;
    logic [2:0]  write_address_d;
    logic [15:0] write_data_d;

    logic [7:0]  busy_q;
    logic [7:0]  busy_d;

    logic [2:0]  head_dest;
    logic [15:0] head_data;
    logic [1:0]  count;

    logic        active;
    logic        fifo_empty;
    logic        ld_acc;
    logic        sel_alu;
    logic        sel_pop;
    logic        sel_byp;
    logic        push;
    logic        retire;
    logic [2:0]  retire_dest;
    logic        drain_done;

    assign active     = (state_q != DONE);
    assign fifo_empty = (count == 2'd0);

    // Ready comes from registered state only; reset forces it low.
    assign ld_ready = !reset && (count < 2'd2) && active;
    assign ld_acc   = ld_valid && ld_ready;

    assign sel_alu = active && alu_valid;
    assign sel_pop = active && !alu_valid && !fifo_empty;
    assign sel_byp = active && !alu_valid && fifo_empty && ld_acc;

    // A bypassed load goes straight to the port, never into the FIFO.
    assign push = ld_acc && !sel_byp;

    writeback_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_dest_i (ld_dest),
        .push_data_i (ld_data),
        .pop_i       (sel_pop),
        .head_dest_o (head_dest),
        .head_data_o (head_data),
        .count_o     (count)
    );

    always_comb begin
        write_d         = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        retire          = 1'b0;
        retire_dest     = 3'd0;
        unique case (1'b1)
            sel_alu: begin
                write_d         = 1'b1;
                write_address_d = alu_dest;
                write_data_d    = alu_data;
            end
            sel_pop: begin
                write_d         = 1'b1;
                write_address_d = head_dest;
                write_data_d    = head_data;
                retire          = 1'b1;
                retire_dest     = head_dest;
            end
            sel_byp: begin
                write_d         = 1'b1;
                write_address_d = ld_dest;
                write_data_d    = ld_data;
                retire          = 1'b1;
                retire_dest     = ld_dest;
            end
            default: ;
        endcase
    end

    // Clear for a retiring load first, so a same-cycle issue to the
    // same register leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (retire) begin
            busy_d[retire_dest] = 1'b0;
        end
        if (ld_issue && (state_q == RUN)) begin
            busy_d[ld_issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q         <= 1'b0;
            write_address_q <= 3'd0;
            write_data_q    <= 16'd0;
            busy_q          <= 8'd0;
        end else begin
            write_q         <= write_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            busy_q          <= busy_d;
        end
    end

    // Nothing left in flight and nothing arriving this cycle.
    assign drain_done = fifo_empty && (busy_q == 8'd0) &&
                        !alu_valid && !ld_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            complete_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        state_q    <= DONE;
                        complete_q <= 1'b1;
                    end
                end
                DONE: begin
                    complete_q <= 1'b1;
                end
                default: begin
                    state_q    <= RUN;
                    complete_q <= 1'b0;
                end
            endcase
        end
    end

    assign write         = write_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign busy          = busy_q;
    assign complete      = complete_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed vector table, hand-written
// drain/reset sequences and randomized traffic against a queue model.

module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        ld_issue;
    logic [2:0]  ld_issue_dest;
    logic        ld_valid;
    logic [2:0]  ld_dest;
    logic [15:0] ld_data;
    logic        ld_ready;
    logic        halt;
    logic        write;
    logic [2:0]  write_address;
    logic [15:0] write_data;
    logic [7:0]  busy;
    logic        complete;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .ld_issue      (ld_issue),
        .ld_issue_dest (ld_issue_dest),
        .ld_valid      (ld_valid),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .ld_ready      (ld_ready),
        .halt          (halt),
        .write         (write),
        .write_address (write_address),
        .write_data    (write_data),
        .busy          (busy),
        .complete      (complete)
    );

    typedef struct {
        logic        rst;
        logic        av;
        logic [2:0]  ad;
        logic [15:0] adt;
        logic        li;
        logic [2:0]  lid;
        logic        lv;
        logic [2:0]  ld;
        logic [15:0] ldt;
        logic        h;
        logic        ew;
        logic [2:0]  ea;
        logic [15:0] ed;
        logic [7:0]  eb;
        logic        ec;
        logic        er;
    } vec_t;

    typedef struct {
        logic [2:0]  dest;
        logic [15:0] data;
    } ent_t;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t tbl[$];

    ent_t       mq[$];
    logic [7:0] mbusy;
    int         mstate;

    function automatic vec_t mk(
        input logic rst, input logic av, input logic [2:0] ad,
        input logic [15:0] adt, input logic li, input logic [2:0] lid,
        input logic lv, input logic [2:0] ld, input logic [15:0] ldt,
        input logic h, input logic ew, input logic [2:0] ea,
        input logic [15:0] ed, input logic [7:0] eb,
        input logic ec, input logic er);
        vec_t v;
        v.rst = rst; v.av = av; v.ad = ad; v.adt = adt;
        v.li = li; v.lid = lid; v.lv = lv; v.ld = ld; v.ldt = ldt;
        v.h = h; v.ew = ew; v.ea = ea; v.ed = ed; v.eb = eb;
        v.ec = ec; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic set_inputs(input vec_t v);
        reset         = v.rst;
        alu_valid     = v.av;
        alu_dest      = v.ad;
        alu_data      = v.adt;
        ld_issue      = v.li;
        ld_issue_dest = v.lid;
        ld_valid      = v.lv;
        ld_dest       = v.ld;
        ld_data       = v.ldt;
        halt          = v.h;
    endtask

    task automatic apply(input vec_t v);
        set_inputs(v);
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        chk({tag, ".write"}, 16'(write), 16'(v.ew));
        if (v.ew || v.rst) begin
            chk({tag, ".addr"}, 16'(write_address), 16'(v.ea));
            chk({tag, ".data"}, write_data, v.ed);
        end
        chk({tag, ".busy"}, 16'(busy), 16'(v.eb));
        chk({tag, ".complete"}, 16'(complete), 16'(v.ec));
        chk({tag, ".ld_ready"}, 16'(ld_ready), 16'(v.er));
    endtask

    task automatic run(input string tag, input vec_t v);
        apply(v);
        check_out(tag, v);
    endtask

    // Reference: queue of accepted loads, ALU first, otherwise the
    // oldest accepted load (including one accepted this cycle).
    task automatic model_step(inout vec_t v);
        ent_t e;
        bit   rdy;
        bit   acc;
        bit   fin;
        v.ew = 1'b0; v.ea = 3'd0; v.ed = 16'd0;
        if (v.rst) begin
            mq.delete();
            mbusy  = 8'd0;
            mstate = 0;
        end else begin
            rdy = (mq.size() < 2) && (mstate != 2);
            acc = v.lv && rdy;
            fin = (mq.size() == 0) && (mbusy == 8'd0) && !v.av && !acc;
            if (mstate != 2) begin
                if (acc) mq.push_back('{v.ld, v.ldt});
                if (v.av) begin
                    v.ew = 1'b1; v.ea = v.ad; v.ed = v.adt;
                end else if (mq.size() != 0) begin
                    e = mq.pop_front();
                    v.ew = 1'b1; v.ea = e.dest; v.ed = e.data;
                    mbusy[e.dest] = 1'b0;
                end
                if (v.li && mstate == 0) mbusy[v.lid] = 1'b1;
            end
            if (mstate == 0 && v.h) mstate = 1;
            else if (mstate == 1 && fin) mstate = 2;
        end
        v.eb = mbusy;
        v.ec = (mstate == 2);
        v.er = !v.rst && (mq.size() < 2) && (mstate != 2);
    endtask

    initial begin
        vec_t v;
        int   done_cnt;

        set_inputs(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,8'h00,0,0));

        // rst av ad adt | li lid | lv ld ldt | h || ew ea ed busy c rdy
        tbl.push_back(mk(1,0,0,0,      0,0, 0,0,0,        0, 0,0,0,        8'h00,0,0));
        tbl.push_back(mk(0,1,3,16'h1234,0,0, 0,0,0,        0, 1,3,16'h1234, 8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      1,5, 0,0,0,        0, 0,0,0,        8'h20,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 1,5,16'hBEEF, 0, 1,5,16'hBEEF, 8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      1,1, 0,0,0,        0, 0,0,0,        8'h02,0,1));
        tbl.push_back(mk(0,0,0,0,      1,2, 0,0,0,        0, 0,0,0,        8'h06,0,1));
        tbl.push_back(mk(0,1,7,16'h0007,0,0, 1,1,16'h1111, 0, 1,7,16'h0007, 8'h06,0,1));
        tbl.push_back(mk(0,1,6,16'h0006,0,0, 1,2,16'h2222, 0, 1,6,16'h0006, 8'h06,0,0));
        tbl.push_back(mk(0,1,6,16'h0066,0,0, 1,3,16'h3333, 0, 1,6,16'h0066, 8'h06,0,0));
        tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0, 1,1,16'h1111, 8'h04,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0, 1,2,16'h2222, 8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0, 0,0,0,        8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      1,4, 0,0,0,        0, 0,0,0,        8'h10,0,1));
        tbl.push_back(mk(0,0,0,0,      1,4, 1,4,16'h4444, 0, 1,4,16'h4444, 8'h10,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 1,4,16'h4545, 0, 1,4,16'h4545, 8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      1,0, 0,0,0,        0, 0,0,0,        8'h01,0,1));
        tbl.push_back(mk(0,1,0,16'hAAAA,0,0, 0,0,0,        0, 1,0,16'hAAAA, 8'h01,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 1,0,16'h0B0B, 0, 1,0,16'h0B0B, 8'h00,0,1));
        tbl.push_back(mk(0,1,1,16'h0001,0,0, 1,3,16'h3003, 0, 1,1,16'h0001, 8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 1,4,16'h4004, 0, 1,3,16'h3003, 8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0, 1,4,16'h4004, 8'h00,0,1));
        tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0,        0, 0,0,0,        8'h00,0,1));

        foreach (tbl[i]) run($sformatf("vec%0d", i), tbl[i]);

        // Halt with one buffered load and r0 pending, then drain.
        run("drn0", mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,0,0));
        run("drn1", mk(0,0,0,0,1,0,0,0,0,0, 0,0,0,8'h01,0,1));
        run("drn2", mk(0,1,1,16'h0101,0,0,1,2,16'h0202,0, 1,1,16'h0101,8'h01,0,1));
        run("drn3", mk(0,1,1,16'h0111,0,0,0,0,0,1, 1,1,16'h0111,8'h01,0,1));
        run("drn4", mk(0,0,0,0,0,0,0,0,0,0, 1,2,16'h0202,8'h01,0,1));
        run("drn5", mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,8'h01,0,1));
        run("drn6", mk(0,0,0,0,0,0,1,0,16'h0F0F,0, 1,0,16'h0F0F,8'h00,0,1));
        run("drn7", mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,1,0));
        run("drn8", mk(0,1,5,16'h5555,1,5,1,5,16'h5A5A,1, 0,0,0,8'h00,1,0));
        run("drn9", mk(0,0,0,0,0,0,1,6,16'h6666,0, 0,0,0,8'h00,1,0));

        // Reset with two buffered loads: they must be discarded.
        run("rst0", mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,0,0));
        run("rst1", mk(0,0,0,0,1,6,0,0,0,0, 0,0,0,8'h40,0,1));
        run("rst2", mk(0,1,1,16'h0001,0,0,1,2,16'h0002,0, 1,1,16'h0001,8'h40,0,1));
        run("rst3", mk(0,1,1,16'h0011,0,0,1,3,16'h0003,0, 1,1,16'h0011,8'h40,0,0));
        run("rst4", mk(1,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,0,0));
        set_inputs(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,0,1));
        #1;
        chk("rst_release.ld_ready", 16'(ld_ready), 16'd1);
        @(posedge clk);
        #1;
        check_out("rst5", mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,0,1));
        run("rst6", mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,0,1));

        // Random traffic against the queue model.
        done_cnt = 0;
        for (int c = 0; c < 1500; c++) begin
            v = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,8'h00,0,0);
            v.rst = (c == 0) || ($urandom_range(0, 399) == 0) || (done_cnt > 6);
            v.av  = ($urandom_range(0, 2) == 0);
            v.ad  = 3'($urandom_range(0, 7));
            v.adt = 16'($urandom);
            v.li  = ($urandom_range(0, 3) == 0);
            v.lid = 3'($urandom_range(0, 7));
            v.lv  = ($urandom_range(0, 1) == 1);
            v.ld  = 3'($urandom_range(0, 7));
            v.ldt = 16'($urandom);
            v.h   = ($urandom_range(0, 99) == 0);
            model_step(v);
            done_cnt = (mstate == 2) ? done_cnt + 1 : 0;
            run($sformatf("rnd%0d", c), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
